// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, byte-writable, unified instruction/data memory
// between the core's instruction fetch port and its data access port.
// At most one access is granted per cycle. The granted access goes to the
// memory in that same cycle. Read data comes back one cycle later and is
// steered to the requester that issued the read.
//
// Data normally wins a conflict. A starve counter bounds how many
// consecutive conflicts data may win before fetch is forced through.
// A saturating conflict counter is exposed for performance tuning.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   i_req/i_addr            instruction fetch request and byte address
//   i_gnt                   fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata        fetch data, one cycle after i_gnt; zero otherwise
//   d_req/d_addr/d_wdata    data request, byte address and store data
//   d_wr_en                 byte write enables; 0 means a load
//   d_gnt                   data request accepted this cycle (combinational)
//   d_rvalid/d_rdata        load data, one cycle after a granted load
//   mem_en/mem_addr         memory strobe and byte address
//   mem_wdata/mem_wr_en     memory write data and byte enables
//   mem_rdata               memory read data (1-cycle latency)
//   conflict_cnt            saturating count of cycles with both requests high
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR       = 16,
  parameter int STARVE_MAX = 3    // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             i_req,
  input  logic [ADDR-1:0]  i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,

  input  logic             d_req,
  input  logic [ADDR-1:0]  d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_wr_en,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,

  output logic             mem_en,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wr_en,
  input  logic [WIDTH-1:0] mem_rdata,

  output logic [15:0]      conflict_cnt
);

  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [15:0] CNT_SAT    = 16'hFFFF;

  // Owner of the read returning this cycle: bit 0 = fetch, bit 1 = data load.
  logic [1:0]  r_tag;
  logic [3:0]  r_starve_cnt;
  logic [15:0] r_conflict_cnt;

  logic w_both;
  logic w_force_i;
  logic w_i_gnt;
  logic w_d_gnt;
  logic w_d_load;

  // ---------------------------------------------------------------------------
  // Grant: data wins by default; fetch wins once data has taken STARVE_MAX
  // consecutive conflicts. Grants depend only on requests and the starve
  // counter, so they stay 0 whenever the requests are 0, even in reset.
  // ---------------------------------------------------------------------------
  assign w_both    = i_req & d_req;
  assign w_force_i = (r_starve_cnt == STARVE_LIM);
  assign w_i_gnt   = i_req & (~d_req | w_force_i);
  assign w_d_gnt   = d_req & ~w_i_gnt;
  assign w_d_load  = w_d_gnt & (d_wr_en == 4'b0000);

  assign i_gnt  = w_i_gnt;
  assign d_gnt  = w_d_gnt;
  assign mem_en = w_i_gnt | w_d_gnt;

  // ---------------------------------------------------------------------------
  // Memory-side mux. An idle cycle and a fetch both drive zero write data and
  // zero enables, so a fetch can never corrupt memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 4'b0000;
    if (w_d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wr_en = d_wr_en;
    end else if (w_i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // State: owner tag, starve counter, conflict counter. Reset is asynchronous,
  // so an in-flight read is dropped and both rvalids fall the moment reset_n
  // goes low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag          <= 2'b00;
      r_starve_cnt   <= 4'd0;
      r_conflict_cnt <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      // Stores produce no read return, so only loads set the data tag bit.
      r_tag <= {w_d_load, w_i_gnt};

      // A conflict that fetch loses means data won it. Fetch is forced at
      // STARVE_LIM, which clears the counter, so it never passes the limit.
      if (!i_req || w_i_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (w_both && (r_starve_cnt < STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      if (w_both && (r_conflict_cnt != CNT_SAT)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return steering: data is forced to zero on the side that does not
  // own the returning read.
  // ---------------------------------------------------------------------------
  assign i_rvalid = r_tag[0];
  assign d_rvalid = r_tag[1];
  assign i_rdata  = r_tag[0] ? mem_rdata : '0;
  assign d_rdata  = r_tag[1] ? mem_rdata : '0;

  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. A bench-side RAM answers the DUT's memory port. A
// reference model predicts grants, memory-side values, read returns and the
// conflict count. The model works from the arbitration rules using integer
// counters and its own copy of memory contents. Inputs change 1 ns after the
// rising edge. Outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int WIDTH      = 32;
  localparam int ADDR       = 16;
  localparam int STARVE_MAX = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_req;
  logic [ADDR-1:0]  i_addr;
  logic             i_gnt;
  logic             i_rvalid;
  logic [WIDTH-1:0] i_rdata;
  logic             d_req;
  logic [ADDR-1:0]  d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [3:0]       d_wr_en;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;
  logic             mem_en;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wr_en;
  logic [WIDTH-1:0] mem_rdata;
  logic [15:0]      conflict_cnt;

  mem_arbiter #(
    .WIDTH      (WIDTH),
    .ADDR       (ADDR),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_gnt        (i_gnt),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_wr_en      (d_wr_en),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr_en    (mem_wr_en),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bench RAM driven only by the DUT's memory port. When no read was issued
  // on the previous cycle, the read data is random, so any leak onto rdata
  // shows up.
  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rdata_q;
  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (mem_en && (mem_wr_en == 4'b0000)) rdata_q <= ram[mem_addr[9:2]];
    else                                  rdata_q <= $urandom;
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_en[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state.
  int          streak;      // consecutive conflicts won by data
  int          conflicts;   // conflicting cycles since reset (unsaturated)
  bit          pend_i, pend_d;
  logic [31:0] pend_i_data, pend_d_data;
  bit          last_i_win, last_d_win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare this cycle's outputs, then roll the model across the next edge.
  task automatic model_step();
    bit          iw, dw;
    logic [15:0] ea;
    logic [31:0] ew;
    logic [3:0]  ee;
    iw = i_req && (!d_req || (streak == STARVE_MAX));
    dw = d_req && !iw;
    ea = '0; ew = '0; ee = '0;
    if (dw) begin
      ea = d_addr; ew = d_wdata; ee = d_wr_en;
    end else if (iw) begin
      ea = i_addr;
    end
    check("i_gnt",     32'(i_gnt),     32'(iw));
    check("d_gnt",     32'(d_gnt),     32'(dw));
    check("mem_en",    32'(mem_en),    32'(iw | dw));
    check("mem_addr",  32'(mem_addr),  32'(ea));
    check("mem_wdata", mem_wdata,      ew);
    check("mem_wr_en", 32'(mem_wr_en), 32'(ee));
    check("i_rvalid",  32'(i_rvalid),  32'(pend_i));
    check("i_rdata",   i_rdata,        pend_i ? pend_i_data : 32'h0);
    check("d_rvalid",  32'(d_rvalid),  32'(pend_d));
    check("d_rdata",   d_rdata,        pend_d ? pend_d_data : 32'h0);
    check("conflict_cnt", 32'(conflict_cnt), (conflicts > 65535) ? 32'd65535 : 32'(conflicts));

    pend_i      = iw;
    pend_i_data = ref_mem[i_addr[9:2]];
    pend_d      = dw && (d_wr_en == 4'b0000);
    pend_d_data = ref_mem[d_addr[9:2]];
    if (dw && (d_wr_en != 4'b0000)) begin
      for (int b = 0; b < 4; b++) begin
        if (d_wr_en[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end
    end
    if (!reset_n) begin
      pend_i = 0; pend_d = 0; streak = 0; conflicts = 0;
    end else begin
      if (i_req && d_req) conflicts++;
      if (!i_req || iw) streak = 0;
      else              streak++;
    end
    last_i_win = iw;
    last_d_win = dw;
  endtask

  task automatic settle();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wr_en = 4'b0000;
  endtask

  // Reset is asynchronous: the model clears at the instant reset_n falls.
  task automatic assert_reset();
    reset_n = 1'b0;
    pend_i = 0; pend_d = 0; streak = 0; conflicts = 0;
  endtask

  logic [5:0]  gd, gi, rd, ri;
  logic [31:0] exp_rd [4];

  initial begin
    for (int k = 0; k < 256; k++) begin
      ram[k]     = 32'hC0DE0000 | 32'(k);
      ref_mem[k] = 32'hC0DE0000 | 32'(k);
    end
    streak = 0; conflicts = 0; pend_i = 0; pend_d = 0;
    last_i_win = 0; last_d_win = 0;
    idle();
    reset_n = 1'b0;

    // Reset state.
    settle();
    check("rst_mem_en",   32'(mem_en),       32'h0);
    check("rst_i_rvalid", 32'(i_rvalid),     32'h0);
    check("rst_d_rvalid", 32'(d_rvalid),     32'h0);
    check("rst_conflict", 32'(conflict_cnt), 32'h0);

    // First fetch after release.
    adv();
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 16'h0040;
    settle();
    check("first_i_gnt",    32'(i_gnt),    32'h1);
    check("first_mem_addr", 32'(mem_addr), 32'h0040);
    check("first_mem_en",   32'(mem_en),   32'h1);
    adv();
    idle();
    settle();
    check("first_i_rvalid", 32'(i_rvalid), 32'h1);
    check("first_i_rdata",  i_rdata,       32'hC0DE0010);

    // Conflict: both requests held for 5 cycles, then dropped.
    adv();
    i_req = 1'b1; i_addr = 16'h0008;
    d_req = 1'b1; d_addr = 16'h0010; d_wr_en = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) idle();
      settle();
      gd[c] = d_gnt; gi[c] = i_gnt; rd[c] = d_rvalid; ri[c] = i_rvalid;
      adv();
    end
    check("conf_d_gnt",    32'(gd), 32'b010111);
    check("conf_i_gnt",    32'(gi), 32'b001000);
    check("conf_d_rvalid", 32'(rd), 32'b101110);
    check("conf_i_rvalid", 32'(ri), 32'b010000);
    check("conf_count",    32'(conflict_cnt), 32'd5);

    // Store, then load it back.
    d_req = 1'b1; d_addr = 16'h0100; d_wdata = 32'hDEADBEEF; d_wr_en = 4'b0011;
    settle();
    check("st_d_gnt",     32'(d_gnt),     32'h1);
    check("st_mem_wr_en", 32'(mem_wr_en), 32'h3);
    check("st_mem_wdata", mem_wdata,      32'hDEADBEEF);
    adv();
    idle();
    settle();
    check("st_no_rvalid", 32'(d_rvalid), 32'h0);
    adv();
    d_req = 1'b1; d_addr = 16'h0100; d_wr_en = 4'b0000;
    settle();
    adv();
    idle();
    settle();
    check("ld_d_rvalid", 32'(d_rvalid), 32'h1);
    check("ld_d_rdata",  d_rdata,       32'hC0DEBEEF);

    // Back-to-back fetches.
    exp_rd[0] = 32'h0; exp_rd[1] = 32'hC0DE0000;
    exp_rd[2] = 32'hC0DE0001; exp_rd[3] = 32'hC0DE0002;
    for (int k = 0; k < 4; k++) begin
      adv();
      if (k < 3) begin
        i_req = 1'b1; i_addr = 16'(k * 4);
      end else begin
        idle();
      end
      settle();
      check("b2b_i_gnt",    32'(i_gnt),    32'(k < 3));
      check("b2b_i_rvalid", 32'(i_rvalid), 32'(k >= 1));
      check("b2b_i_rdata",  i_rdata,       exp_rd[k]);
    end

    // Reset asserted while a load is granted, before the edge.
    adv();
    d_req = 1'b1; d_addr = 16'h0020; d_wr_en = 4'b0000;
    settle();
    check("mid_d_gnt", 32'(d_gnt), 32'h1);
    assert_reset();
    adv();
    idle();
    settle();
    check("mid_no_rvalid", 32'(d_rvalid), 32'h0);
    adv();
    reset_n = 1'b1;
    settle();
    check("mid_rel_rvalid0", 32'(d_rvalid), 32'h0);
    adv();
    settle();
    check("mid_rel_rvalid1", 32'(d_rvalid), 32'h0);

    // Reset while a read is returning: rvalid must drop at once.
    adv();
    d_req = 1'b1; d_addr = 16'h0024; d_wr_en = 4'b0000;
    settle();
    adv();
    idle();
    settle();
    check("ret_d_rvalid", 32'(d_rvalid), 32'h1);
    assert_reset();
    #1;
    check("async_d_rvalid", 32'(d_rvalid), 32'h0);
    adv();
    reset_n = 1'b1;
    settle();

    // Randomized traffic with occasional resets; requests hold until granted.
    for (int n = 0; n < 4000; n++) begin
      adv();
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        assert_reset();
      end
      if (!(i_req && !last_i_win)) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = 16'($urandom_range(0, 255)) << 2;
      end
      if (!(d_req && !last_d_win)) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_addr  = 16'($urandom_range(0, 255)) << 2;
        d_wdata = $urandom;
        d_wr_en = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      end
      settle();
    end

    // Saturation: both requests high long enough to pass 16'hFFFF.
    adv();
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 16'h0004;
    d_req = 1'b1; d_addr = 16'h0008; d_wr_en = 4'b0000;
    for (int n = 0; n < 65540; n++) begin
      settle();
      adv();
    end
    settle();
    check("sat_count", 32'(conflict_cnt), 32'h0000FFFF);
    for (int n = 0; n < 10; n++) begin
      adv();
      settle();
    end
    check("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
